signed_div: RTL and testbench

Sequential signed integer divider, the inverse companion of the team's 11×11 sequential signed multiplier. It divides a 22-bit two's-complement dividend by an 11-bit two's-complement divisor using a one-bit-per-cycle restoring algorithm on magnitudes, followed by sign correction. It returns a 22-bit quotient truncated toward zero and an 11-bit remainder, and sits beside the multiplier in the arithmetic datapath to recover factors from products.

---
 rtl/signed_div.sv | 151 +++++++++++++++
 tb/tb_signed_div.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_div.sv
// -----------------------------------------------------------------------------
// signed_div
//
// Sequential signed divider. It divides a 22-bit two's-complement dividend by
// an 11-bit two's-complement divisor. The core is a one-bit-per-cycle restoring
// divider that works on magnitudes, and a final cycle applies the signs.
// The quotient truncates toward zero. The remainder takes the sign of the
// dividend. It pairs with the 11x11 sequential signed multiplier.
//
// Latency: valid rises 23 clocks after the accepted start edge.
// That is 22 iteration cycles plus 1 sign-correction cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (0 = reset asserted)
//   start      request; only accepted in IDLE or DONE
//   dividend   22-bit signed dividend, captured on an accepted start
//   divisor    11-bit signed divisor, captured on an accepted start
//   quotient   22-bit signed quotient, truncated toward zero
//   remainder  11-bit signed remainder, sign follows the dividend
//   busy       high while iterating or correcting signs
//   valid      high in DONE; results hold while high
//   div_zero   divisor was zero (qualified by valid)
//   ovf        quotient not representable (qualified by valid)
// -----------------------------------------------------------------------------
module signed_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [21:0] dividend,
  input  logic [10:0] divisor,
  output logic [21:0] quotient,
  output logic [10:0] remainder,
  output logic        busy,
  output logic        valid,
  output logic        div_zero,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        sd;
  logic        sv;
  logic [21:0] dvd_mag;
  logic [10:0] dvs_mag;
  logic [21:0] q_mag;
  // The partial remainder is always below the divisor magnitude, which is at
  // most 1024. So 11 stored bits are enough. The 12-bit headroom only exists
  // in the shifted and trial values.
  logic [10:0] rem;

  logic [11:0] shifted;
  logic [11:0] trial;
  logic [21:0] dividend_abs;
  logic [10:0] divisor_abs;
  logic [21:0] q_neg;
  logic [10:0] rem_neg;

  // Magnitudes and negations. -2^21 and -1024 map onto themselves as
  // unsigned values, and those values are exactly the magnitudes wanted.
  always_comb begin
    shifted      = {rem, dvd_mag[21]};
    trial        = shifted - {1'b0, dvs_mag};
    dividend_abs = dividend[21] ? (~dividend + 22'd1) : dividend;
    divisor_abs  = divisor[10] ? (~divisor + 11'd1) : divisor;
    q_neg        = ~q_mag + 22'd1;
    rem_neg      = ~rem + 11'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      sd        <= 1'b0;
      sv        <= 1'b0;
      dvd_mag   <= 22'd0;
      dvs_mag   <= 11'd0;
      q_mag     <= 22'd0;
      rem       <= 11'd0;
      quotient  <= 22'd0;
      remainder <= 11'd0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sd      <= dividend[21];
            sv      <= divisor[10];
            dvd_mag <= dividend_abs;
            dvs_mag <= divisor_abs;
            q_mag   <= 22'd0;
            rem     <= 11'd0;
            cnt     <= 5'd0;
            busy    <= 1'b1;
            valid   <= 1'b0;
            state   <= CAL;
          end
        end
        CAL: begin
          // The subtraction is kept only when it does not borrow. That is the
          // restoring step, and it yields one quotient bit per cycle.
          if (!trial[11]) begin
            rem   <= trial[10:0];
            q_mag <= {q_mag[20:0], 1'b1};
          end else begin
            rem   <= shifted[10:0];
            q_mag <= {q_mag[20:0], 1'b0};
          end
          dvd_mag <= {dvd_mag[20:0], 1'b0};
          cnt     <= cnt + 5'd1;
          if (cnt == 5'd21) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          // Divide-by-zero throws away the iteration results.
          // A positive quotient magnitude of 2^21 cannot be represented,
          // which only happens for -2^21 / -1.
          if (dvs_mag == 11'd0) begin
            quotient  <= 22'd0;
            remainder <= 11'd0;
            div_zero  <= 1'b1;
            ovf       <= 1'b0;
          end else begin
            quotient  <= (sd ^ sv) ? q_neg : q_mag;
            remainder <= sd ? rem_neg : rem;
            div_zero  <= 1'b0;
            ovf       <= ~(sd ^ sv) & q_mag[21];
          end
          busy  <= 1'b0;
          valid <= 1'b1;
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div.sv
// -----------------------------------------------------------------------------
// tb_signed_div
//
// Directed testbench for signed_div. Each scenario task drives its own stimulus
// and compares the outputs against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_signed_div;

  logic        clk;
  logic        reset;
  logic        start;
  logic [21:0] dividend;
  logic [10:0] divisor;
  logic [21:0] quotient;
  logic [10:0] remainder;
  logic        busy;
  logic        valid;
  logic        div_zero;
  logic        ovf;

  int vectors;
  int miscompares;

  signed_div dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .valid     (valid),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents operands with a single-cycle start. It returns 1 ns after the
  // accepting edge, which is edge k.
  task automatic launch(input int dd, input int dv);
    @(negedge clk);
    dividend = 22'(dd);
    divisor  = 11'(dv);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until valid is seen. The count is bounded, and a timeout
  // returns 99.
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!valid) n = 99;
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    start    = 1'b0;
    dividend = 22'd0;
    divisor  = 11'd0;
    #1;
    vectors++;
    if ({quotient, remainder, busy, valid, div_zero, ovf} !== 37'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got q=%h r=%h b=%b v=%b dz=%b ovf=%b, want all 0",
               quotient, remainder, busy, valid, div_zero, ovf);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_release: got busy=%b valid=%b, want 0 0", busy, valid);
    end
  endtask

  task automatic test_signs;
    int dd [4] = '{1000, -1000, 1000, -1000};
    int dv [4] = '{7, 7, -7, -7};
    int eq [4] = '{142, -142, -142, 142};
    int er [4] = '{6, -6, 6, -6};
    int n;
    for (int i = 0; i < 4; i++) begin
      launch(dd[i], dv[i]);
      vectors++;
      if (busy !== 1'b1 || valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL busy_after_start[%0d]: got busy=%b valid=%b, want 1 0", i, busy, valid);
      end
      wait_valid(n);
      vectors++;
      if (n !== 23) begin
        miscompares++;
        $display("[TB] FAIL latency[%0d]: got %0d, want 23", i, n);
      end
      vectors++;
      if (quotient !== 22'(eq[i]) || remainder !== 11'(er[i])) begin
        miscompares++;
        $display("[TB] FAIL div[%0d] %0d/%0d: got q=%h r=%h, want q=%h r=%h",
                 i, dd[i], dv[i], quotient, remainder, 22'(eq[i]), 11'(er[i]));
      end
      vectors++;
      if (div_zero !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL flags[%0d]: got dz=%b ovf=%b busy=%b, want 0 0 0", i, div_zero, ovf, busy);
      end
    end
  endtask

  task automatic test_extremes;
    int dd [3] = '{2097151, -2097152, -2097152};
    int dv [3] = '{-1024, -1024, -1};
    int eq [3] = '{-2047, 2048, -2097152};
    int er [3] = '{1023, 0, 0};
    logic eo [3] = '{1'b0, 1'b0, 1'b1};
    int n;
    for (int i = 0; i < 3; i++) begin
      launch(dd[i], dv[i]);
      wait_valid(n);
      vectors++;
      if (n !== 23) begin
        miscompares++;
        $display("[TB] FAIL ext_latency[%0d]: got %0d, want 23", i, n);
      end
      vectors++;
      if (quotient !== 22'(eq[i]) || remainder !== 11'(er[i]) || ovf !== eo[i] || div_zero !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL ext[%0d]: got q=%h r=%h ovf=%b dz=%b, want q=%h r=%h ovf=%b dz=0",
                 i, quotient, remainder, ovf, div_zero, 22'(eq[i]), 11'(er[i]), eo[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int n;
    launch(12345, 0);
    wait_valid(n);
    vectors++;
    if (n !== 23) begin
      miscompares++;
      $display("[TB] FAIL dz_latency: got %0d, want 23", n);
    end
    vectors++;
    if (div_zero !== 1'b1 || quotient !== 22'd0 || remainder !== 11'd0 || ovf !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL dz_result: got dz=%b q=%h r=%h ovf=%b, want 1 0 0 0",
               div_zero, quotient, remainder, ovf);
    end
  endtask

  task automatic test_ignore_start;
    int n;
    launch(1000, 7);
    n = 0;
    while (!valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 5) begin
        start    = 1'b1;
        dividend = 22'd5;
        divisor  = 11'd1;
      end
      if (n == 6) start = 1'b0;
    end
    vectors++;
    if (n !== 23) begin
      miscompares++;
      $display("[TB] FAIL ignore_latency: got %0d, want 23", n);
    end
    vectors++;
    if (quotient !== 22'd142 || remainder !== 11'd6) begin
      miscompares++;
      $display("[TB] FAIL ignore_result: got q=%h r=%h, want q=%h r=%h", quotient, remainder, 22'd142, 11'd6);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    dividend = 22'(-1000);
    divisor  = 11'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    wait_valid(n);
    vectors++;
    if (n !== 23 || quotient !== 22'(-142)) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got n=%0d q=%h, want n=23 q=%h", n, quotient, 22'(-142));
    end
    @(posedge clk);
    #1;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_restart: got valid=%b busy=%b, want 0 1", valid, busy);
    end
    wait_valid(n);
    vectors++;
    if (n !== 23 || remainder !== 11'(-6)) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got n=%0d (+1) r=%h, want 23 (+1) r=%h", n, remainder, 11'(-6));
    end
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_midreset;
    int n;
    launch(1000, 7);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({quotient, remainder, busy, valid, div_zero, ovf} !== 37'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got q=%h r=%h b=%b v=%b dz=%b ovf=%b, want all 0",
               quotient, remainder, busy, valid, div_zero, ovf);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_idle: got busy=%b valid=%b, want 0 0", busy, valid);
    end
    launch(1000, 7);
    wait_valid(n);
    vectors++;
    if (n !== 23 || quotient !== 22'd142 || remainder !== 11'd6) begin
      miscompares++;
      $display("[TB] FAIL after_reset: got n=%0d q=%h r=%h, want 23 %h %h", n, quotient, remainder, 22'd142, 11'd6);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_signs();
    test_extremes();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
